load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port: accepts byte-addressed load/store requests from the execute stage and drives the word-addressed data memory (enable, read/write select, word address, write data), returning formatted load data. Performs little-endian byte/halfword lane selection, sign/zero extension, and read-modify-write for sub-word stores, because the memory only writes whole words. Sits between the pipeline's MEM stage and the data memory.

## Interface
- MEM_DEPTH, 21, number of 32-bit words in the attached data memory
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  formatted load data, valid with resp_valid; 0 for stores
- resp_err  out  1  valid with resp_valid; see Configuration
- mem_EN  out  1  memory enable
- mem_RW  out  1  0 read, 1 write
- mem_ADDr  out  32  word index = req_addr[31:2]
- mem_Din  out  32  full word to write
- mem_Dout  in  32  memory read data, valid the cycle after a read-enabled edge

## Operation
- States: IDLE, RD, RD_WAIT, WR, RESP. Request fields latched on accept.
- Load: IDLE → RD (mem_EN=1, mem_RW=0) → RD_WAIT (mem_EN=0; mem_Dout sampled at end) → RESP → IDLE.
- Store word: IDLE → WR (mem_EN=1, mem_RW=1, mem_Din=wdata) → RESP → IDLE.
- Store byte/half: IDLE → RD → RD_WAIT (merge new lanes into sampled word, register into mem_Din) → WR → RESP → IDLE.
- Lane select: off = addr[1:0]; byte uses mem_Dout[8*off+7 : 8*off]; half uses [15:0] if addr[1]=0 else [31:16]. Extension per req_unsigned; word passes through.
- Out of range (word index ≥ MEM_DEPTH): no memory access; IDLE → RESP directly; loads return 0, stores dropped, resp_err=0.
- mem_EN low in IDLE, RD_WAIT, RESP; mem_ADDr/mem_Din hold last values when mem_EN=0.
- req_ready low from accept through RESP; no back-to-back acceptance in RESP.

## Timing
- Accept at edge T0. Load: resp_valid during T2–T3. Store word: during T1–T2. Sub-word store: during T3–T4. Out-of-range/trapped: during T1–T2.
- All outputs registered except req_ready (decoded from state).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_EN=0, mem_RW=0, mem_ADDr=0, mem_Din=0.
- Reset mid-operation: mem_EN drops immediately; an in-flight WR whose edge has not arrived performs no write; RMW partially completed leaves memory unchanged.

## Configuration
- MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 causes no memory access, RESP after one cycle with resp_err=1, resp_rdata=0.
- Undefined: misaligned low bits ignored (half uses addr[1] only, word ignores addr[1:0]); resp_err tied 0.

## Structure
- Shared package: state encoding (3-bit localparams), size codes SZ_B/SZ_H/SZ_W.
- One sub-module: lsu_lane_fmt (combinational: load extract/extend and store merge), instantiated once for each direction.

## Test plan
- Word store 0xDEADBEEF at 0x08, then word load 0x08 → mem_ADDr=2, resp_rdata=0xDEADBEEF, latencies 1 and 2 cycles.
- Signed byte load at 0x0B from word 0x80FF1234 → 0xFFFFFF80; unsigned → 0x00000080.
- Half store 0xA5A5 at 0x0A over 0x11223344 → memory word 0xA5A53344, resp_valid 3 cycles after accept.
- Load at 0x60 (index 24 ≥ 21) → no mem_EN, resp_rdata=0, resp 1 cycle after accept.
- Word load at 0x06: with MISALIGN_TRAP_EN → resp_err=1, no mem_EN; without → reads index 1.
- RST_N low during WR of sub-word store → mem_EN=0 at once, target word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and
// access-size codes. Imported by load_store_unit and lsu_lane_fmt.
package load_store_unit_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    // Access size codes; 2'b11 behaves as a word everywhere (size[1] set)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/load_store_unit_lane_fmt.sv
// lsu_lane_fmt: combinational little-endian lane handling.
//   LOAD=1: extract byte/half from word_i at offset off_i, sign/zero extend.
//   LOAD=0: merge wdata_i's low byte/half into word_i (read-modify-write).
// Ports:
//   size_i     access size (SZ_B/SZ_H/SZ_W, 11 = word)
//   unsigned_i load extension: 1 zero, 0 sign
//   off_i      byte offset within the word (addr[1:0])
//   word_i     memory word
//   wdata_i    right-aligned store data
//   data_o     formatted load data or merged store word
module lsu_lane_fmt
    import load_store_unit_pkg::*;
#(
    parameter bit LOAD = 1'b1
) (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        // halves select on addr[1] only; addr[0] is ignored here
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        ld_data = word_i;
        st_data = wdata_i;
        case (size_i)
            SZ_B: begin
                ld_data = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                st_data = word_i;
                st_data[8*off_i +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                ld_data = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                st_data = word_i;
                st_data[16*off_i[1] +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase

        data_o = LOAD ? ld_data : st_data;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store requests to a word-addressed
// data memory with lane select, extension and sub-word read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word -> resp_err).
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   req_*                      request (valid/ready handshake, accepted in IDLE)
//   resp_valid/rdata/err       one-cycle registered response
//   mem_EN/RW/ADDr/Din, mem_Dout  data memory port (1-cycle read latency)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_DEPTH = 21
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_EN,
    output logic        mem_RW,
    output logic [31:0] mem_ADDr,
    output logic [31:0] mem_Din,
    input  logic [31:0] mem_Dout
);

    logic [2:0]  state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        mem_en_q;
    logic        mem_rw_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;

    logic [31:0] ld_data_d;
    logic [31:0] merge_d;
    logic        oor;
    logic        misal;

    assign oor = {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);

`ifdef MISALIGN_TRAP_EN
    logic resp_err_q;
    logic trap_q;
    assign misal = ((req_size == SZ_H) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err = resp_err_q;
`else
    assign misal = 1'b0;
    assign resp_err = 1'b0;
`endif

    lsu_lane_fmt #(.LOAD(1'b1)) u_ld_fmt (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .off_i      (off_q),
        .word_i     (mem_Dout),
        .wdata_i    (32'd0),
        .data_o     (ld_data_d)
    );

    lsu_lane_fmt #(.LOAD(1'b0)) u_st_fmt (
        .size_i     (size_q),
        .unsigned_i (1'b0),
        .off_i      (off_q),
        .word_i     (mem_Dout),
        .wdata_i    (wdata_q),
        .data_o     (merge_d)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_EN     = mem_en_q;
    assign mem_RW     = mem_rw_q;
    assign mem_ADDr   = mem_addr_q;
    assign mem_Din    = mem_din_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
            trap_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
                        resp_err_q <= 1'b0;
                        trap_q     <= misal;
`endif
                        if (oor || misal) begin
                            // no access: RESP is entered with resp_valid low so
                            // the pulse lands one cycle after accept
                            state_q <= S_RESP;
                        end else if (req_we && req_size[1]) begin
                            state_q    <= S_WR;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b1;
                            mem_addr_q <= {2'b00, req_addr[31:2]};
                            mem_din_q  <= req_wdata;
                        end else begin
                            state_q    <= S_RD;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b0;
                            mem_addr_q <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                S_RD: begin
                    mem_en_q <= 1'b0;
                    state_q  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (we_q) begin
                        mem_din_q <= merge_d;
                        mem_en_q  <= 1'b1;
                        mem_rw_q  <= 1'b1;
                        state_q   <= S_WR;
                    end else begin
                        resp_rdata_q <= ld_data_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_WR: begin
                    mem_en_q     <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_valid_q) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
                        resp_err_q   <= trap_q;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
